// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster counter with sync/de/strobe decode, delayed by a ce-gated pipeline.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int DELAY    = 1,
    parameter int CW       = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               CLK25,
    input  logic               Reset,
    input  logic               ce,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic [CW-1:0]      sx,
    output logic [CW-1:0]      sy,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_SS   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SE   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_SS   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SE   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic          de;
        logic          hs;
        logic          vs;
        logic          ls;
        logic          fs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } stage_t;

    localparam stage_t IDLE = '{de: 1'b0, hs: !H_POL, vs: !V_POL, ls: 1'b0, fs: 1'b0, x: '0, y: '0};

    logic [CW-1:0] hc, vc;
    logic          h_end, v_end;
    stage_t        cur;
    stage_t        pipe [DELAY];

    assign h_end = hc == H_LAST;
    assign v_end = vc == V_LAST;
    assign cur = '{
        de: hc < H_VIS && vc < V_VIS,
        hs: (hc >= H_SS && hc < H_SE) ? H_POL : !H_POL,
        vs: (vc >= V_SS && vc < V_SE) ? V_POL : !V_POL,
        ls: hc == '0,
        fs: hc == '0 && vc == '0,
        x:  hc,
        y:  vc
    };

    // frame_cnt tracks the counter directly; only the decoded vector is delayed
    always_ff @(posedge CLK25) begin
        if (Reset) begin
            hc        <= '0;
            vc        <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < DELAY; i++) pipe[i] <= IDLE;
        end else if (ce) begin
            hc        <= h_end ? '0 : hc + 1'b1;
            vc        <= h_end ? (v_end ? '0 : vc + 1'b1) : vc;
            frame_cnt <= frame_cnt + FRAME_W'(h_end && v_end);
            pipe[0]   <= cur;
            for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign de          = pipe[DELAY-1].de;
    assign h_sync      = pipe[DELAY-1].hs;
    assign v_sync      = pipe[DELAY-1].vs;
    assign line_start  = pipe[DELAY-1].ls;
    assign frame_start = pipe[DELAY-1].fs;
    assign sx          = pipe[DELAY-1].x;
    assign sy          = pipe[DELAY-1].y;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/DVI raster timing generator, the next generation of the team's fixed 640x480 sync block. Counts pixel position, decodes horizontal/vertical sync with programmable polarity, active-video enable, and line/frame strobes, all aligned through a configurable output delay so the syncs match the latency of the downstream pixel pipeline. A clock-enable input lets the block run from a faster system clock. It sits between the clock/reset infrastructure and the pixel renderer/colour output stage.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, h_sync active level (0 = active-low)
- V_POL, 0, v_sync active level (0 = active-low)
- DELAY, 1, output pipeline depth in pixel ticks (1..8)
- CW, 10, width of sx/sy; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8, frame counter width
- CLK25 input 1 pixel/system clock; all logic on its rising edge
- Reset input 1 synchronous, active-high
- ce input 1 pixel tick enable; tie high for one pixel per clock
- h_sync output 1 horizontal sync, level per H_POL
- v_sync output 1 vertical sync, level per V_POL
- de output 1 active video (1 = visible pixel)
- sx output CW pixel column of the current output
- sy output CW line of the current output
- line_start output 1 high for the pixel tick where sx==0
- frame_start output 1 high for the pixel tick where sx==0 and sy==0
- frame_cnt output FRAME_W completed frames, modulo 2^FRAME_W

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counter (hc, vc): on each ce, hc increments; at hc==H_TOTAL-1, hc->0 and vc increments; at vc==V_TOTAL-1 with hc wrap, vc->0.
- Decode from (hc, vc): de = hc<H_ACTIVE && vc<V_ACTIVE; h active when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; v active when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC; output level = active ? POL : !POL.
- Decoded vector (de, syncs, hc, vc, strobes) enters a DELAY-deep shift register advanced only on ce; outputs are the last stage, all registered, mutually aligned.
- frame_cnt increments (wraps) on the ce where the counter wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0); it is not delayed.
- ce low: counter, pipeline and frame_cnt hold; outputs hold their value.

## Timing
- Reset (any cycle, including mid-frame, ce ignored): hc=vc=0, every pipeline stage cleared to de=0, h_sync=!H_POL, v_sync=!V_POL, sx=sy=0, line_start=frame_start=0; frame_cnt=0.
- First ce after Reset deasserts registers decode of (0,0) into stage 1; outputs show (0,0), de=1, line_start=frame_start=1 after the DELAY-th ce edge. Earlier outputs remain at reset values.
- Latency counter-to-output: exactly DELAY ce ticks.
- Strobes are one pixel tick wide (high until the next ce edge).
- Reset and ce together: Reset wins.
- Sync width on outputs: exactly H_SYNC pixel ticks / V_SYNC lines; v_sync edges coincide with hc==0 boundaries.

## Test plan
- Defaults, ce=1, Reset pulsed: after 1 clock sx=0, sy=0, de=1, frame_start=1; h_sync low exactly for sx 656..751, v_sync low for sy 490..491; de high 640x480 per frame; 420000 clocks per frame.
- Small params H 4/1/2/1, V 3/1/1/1, H_POL=1, V_POL=1, DELAY=1: line 8 ticks, frame 48 ticks; h_sync high at sx 5..6, v_sync high at sy 4; frame_cnt 0->1 after the 48th tick wraps.
- ce=1 every third clock: outputs change only on ce clocks; frame takes 3x clocks; no strobe wider than one tick.
- DELAY=4: outputs identical to DELAY=1 run, shifted by 3 ticks; first 3 ticks after reset show reset values.
- Reset asserted mid-frame at (300,200) with ce=1: next clock all outputs at reset values, frame_cnt=0; sequence restarts from (0,0).
- FRAME_W=2: frame_cnt sequence 1,2,3,0 over four frames.
